// File: rtl/filt_sched.sv
// filt_sched: multi-channel sequencer for the ADPCM quantizer scale factor
// adaptation averaging filters (short-term DMS, long-term DML).
// One update request per sample is accepted when idle. A single
// subtract/shift/add unit is time-shared between the DMS and DML updates.
// Results are returned with a one-cycle done pulse 4 cycles after accept.
//
// Optional feature: define FILT_SCHED_DROP_CNT_EN to count requests that
// are not accepted (saturating at 255, cleared only by reset). When it is
// undefined, drop_cnt is tied to 0.
//
// Ports:
//   clk      system clock
//   reset    asynchronous active-low reset
//   init     start clearing all channel state
//   req      update request (sampled only while idle)
//   req_ch   channel to update
//   req_fi   FI value for this update
//   busy     sequencer not idle
//   done     one-cycle pulse, results valid
//   done_ch  channel of the completed update
//   dms_out  updated short-term average DMSP
//   dml_out  updated long-term average DMLP
//   drop_cnt dropped-request count (optional feature)
module filt_sched #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CHW = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           init,
    input  logic           req,
    input  logic [CHW-1:0] req_ch,
    input  logic [2:0]     req_fi,
    output logic           busy,
    output logic           done,
    output logic [CHW-1:0] done_ch,
    output logic [11:0]    dms_out,
    output logic [13:0]    dml_out,
    output logic [7:0]     drop_cnt
);

    typedef enum logic [2:0] {IDLE, INIT, LOAD, UPD_S, UPD_L, WB} state_t;

    state_t         state;
    state_t         state_nxt;
    logic           accept;
    logic           ch_ok;

    logic [11:0]    dms_mem [NCH];
    logic [13:0]    dml_mem [NCH];
    logic [CHW-1:0] ch_q;
    logic [2:0]     fi_q;
    logic [11:0]    dms_w;
    logic [13:0]    dml_w;
    logic [CHW-1:0] clr_cnt;

    // shared datapath signals
    logic           is_l;
    logic [14:0]    minuend;
    logic [14:0]    subtrahend;
    logic [2:0]     shamt;
    logic [7:0]     shf;
    logic [13:0]    difsx;
    logic [13:0]    addend;
    logic [13:0]    sum;

    assign ch_ok = (32'(req_ch) < NCH);

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (init) begin
                    state_nxt = INIT;
                end else if (req && ch_ok) begin
                    state_nxt = LOAD;
                    accept    = 1'b1;
                end
            end
            INIT:    if (clr_cnt == CHW'(NCH - 1)) state_nxt = IDLE;
            LOAD:    state_nxt = UPD_S;
            UPD_S:   state_nxt = UPD_L;
            UPD_L:   state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shared unit: the 13-bit DMS difference is the low bits of the 15-bit
    // subtraction; after the 5/7 shift the sign lands in bit 7 either way.
    always_comb begin
        is_l       = (state == UPD_L);
        minuend    = is_l ? {1'b0, fi_q, 11'b0} : {3'b0, fi_q, 9'b0};
        subtrahend = is_l ? {1'b0, dml_w} : {3'b0, dms_w};
        shamt      = is_l ? 3'd7 : 3'd5;
        shf        = 8'((minuend - subtrahend) >> shamt);
        difsx      = is_l ? {{6{shf[7]}}, shf} : {2'b0, {4{shf[7]}}, shf};
        addend     = is_l ? dml_w : {2'b0, dms_w};
        sum        = difsx + addend;
    end

    // channel state, working registers and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                dms_mem[i] <= 12'd0;
                dml_mem[i] <= 14'd0;
            end
            ch_q    <= '0;
            fi_q    <= 3'd0;
            dms_w   <= 12'd0;
            dml_w   <= 14'd0;
            clr_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_ch <= '0;
            dms_out <= 12'd0;
            dml_out <= 14'd0;
        end else begin
            busy <= (state_nxt != IDLE);
            done <= (state == WB);
            case (state)
                IDLE: begin
                    clr_cnt <= '0;
                    if (accept) begin
                        ch_q <= req_ch;
                        fi_q <= req_fi;
                    end
                end
                INIT: begin
                    dms_mem[clr_cnt] <= 12'd0;
                    dml_mem[clr_cnt] <= 14'd0;
                    clr_cnt          <= CHW'(clr_cnt + 1'b1);
                end
                LOAD: begin
                    dms_w <= dms_mem[ch_q];
                    dml_w <= dml_mem[ch_q];
                end
                UPD_S: dms_w <= sum[11:0];
                UPD_L: dml_w <= sum;
                WB: begin
                    dms_mem[ch_q] <= dms_w;
                    dml_mem[ch_q] <= dml_w;
                    done_ch       <= ch_q;
                    dms_out       <= dms_w;
                    dml_out       <= dml_w;
                end
                default: ;
            endcase
        end
    end

`ifdef FILT_SCHED_DROP_CNT_EN
    // any request not accepted this cycle counts as dropped
    logic drop;
    assign drop = req && !accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          drop_cnt <= 8'd0;
        else if (drop && drop_cnt != 8'hFF)  drop_cnt <= drop_cnt + 8'd1;
    end
`else
    assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_filt_sched.sv
// Self-checking bench for filt_sched: directed cases plus randomized updates
// compared against an arithmetic reference model of the averaging filters.
module tb_filt_sched;

    localparam int unsigned NCH = 4;
    localparam int unsigned CHW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           init;
    logic           req;
    logic [CHW-1:0] req_ch;
    logic [2:0]     req_fi;
    logic           busy;
    logic           done;
    logic [CHW-1:0] done_ch;
    logic [11:0]    dms_out;
    logic [13:0]    dml_out;
    logic [7:0]     drop_cnt;

    int nvec = 0;
    int nerr = 0;
    int m_dms [NCH];
    int m_dml [NCH];

    filt_sched #(.NCH(NCH), .CHW(CHW)) dut (
        .clk      (clk),
        .reset    (reset),
        .init     (init),
        .req      (req),
        .req_ch   (req_ch),
        .req_fi   (req_fi),
        .busy     (busy),
        .done     (done),
        .done_ch  (done_ch),
        .dms_out  (dms_out),
        .dml_out  (dml_out),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        nvec++;
        if (obs != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // reference filter arithmetic
    function automatic int f_dms(input int d, input int fi);
        int dif, dsx;
        dif = ((fi * 512) + 8192 - d) % 8192;
        dsx = dif / 32;
        if (dif >= 4096) dsx += 3840;
        return (dsx + d) % 4096;
    endfunction

    function automatic int f_dml(input int d, input int fi);
        int dif, dsx;
        dif = ((fi * 2048) + 32768 - d) % 32768;
        dsx = dif / 128;
        if (dif >= 16384) dsx += 16128;
        return (dsx + d) % 16384;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < int'(NCH); i++) begin
            m_dms[i] = 0;
            m_dml[i] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // issue one request while idle and check latency, results and done pulse
    task automatic upd(input int ch, input int fi);
        int lat;
        int es, el;
        es = f_dms(m_dms[ch], fi);
        el = f_dml(m_dml[ch], fi);
        req    = 1'b1;
        req_ch = CHW'(ch);
        req_fi = 3'(fi);
        tick();
        req = 1'b0;
        check("busy_after_accept", int'(busy), 1);
        lat = 0;
        while (!done && lat < 10) begin
            tick();
            lat++;
        end
        check("latency", lat, 4);
        check("done_ch", int'(done_ch), ch);
        check("dms_out", int'(dms_out), es);
        check("dml_out", int'(dml_out), el);
        m_dms[ch] = es;
        m_dml[ch] = el;
        tick();
        check("done_pulse_end", int'(done), 0);
    endtask

    initial begin
        int n, ndone, d0, ch, fi;
        reset  = 1'b0;
        init   = 1'b0;
        req    = 1'b0;
        req_ch = '0;
        req_fi = 3'd0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_dms", int'(dms_out), 0);
        check("rst_dml", int'(dml_out), 0);
        check("rst_drop", int'(drop_cnt), 0);
        reset = 1'b1;
        tick();

        // directed sequence on channel 0 with channel 1 interleaved
        upd(0, 7);
        check("tp1_dms", int'(dms_out), 112);
        check("tp1_dml", int'(dml_out), 112);
        upd(1, 7);
        check("tp_ch1_dms", int'(dms_out), 112);
        upd(0, 7);
        check("tp2_dms", int'(dms_out), 220);
        check("tp2_dml", int'(dml_out), 223);
        upd(0, 0);
        upd(1, 0);

        // request while busy is ignored: exactly one done
        d0 = int'(drop_cnt);
        req = 1'b1; req_ch = 2'd2; req_fi = 3'd5;
        tick();
        req = 1'b0;
        tick();
        req = 1'b1; req_ch = 2'd3; req_fi = 3'd1;
        tick();
        req = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) ndone++;
            tick();
        end
        check("busy_req_dones", ndone, 1);
        check("busy_req_ch", int'(done_ch), 2);
        check("busy_req_dms", int'(dms_out), f_dms(m_dms[2], 5));
        m_dms[2] = f_dms(m_dms[2], 5);
        m_dml[2] = f_dml(m_dml[2], 5);
`ifdef FILT_SCHED_DROP_CNT_EN
        check("drop_busy", int'(drop_cnt) - d0, 1);
`else
        check("drop_tied", int'(drop_cnt), 0);
`endif

        // randomized updates against the model
        for (int k = 0; k < 40; k++) begin
            ch = int'($urandom_range(0, NCH - 1));
            fi = int'($urandom_range(0, 7));
            upd(ch, fi);
        end

        // init with a simultaneous request: busy NCH cycles, no done
        d0 = int'(drop_cnt);
        init = 1'b1; req = 1'b1; req_ch = 2'd1; req_fi = 3'd3;
        tick();
        init = 1'b0; req = 1'b0;
        n = 0; ndone = 0;
        while (busy && n < 20) begin
            if (done) ndone++;
            n++;
            tick();
        end
        check("init_busy_cycles", n, int'(NCH));
        check("init_no_done", ndone, 0);
`ifdef FILT_SCHED_DROP_CNT_EN
        check("drop_init", int'(drop_cnt) - d0, 1);
`else
        check("drop_tied2", int'(drop_cnt), 0);
`endif
        clear_model();
        upd(0, 7);
        check("post_init_dms", int'(dms_out), 112);
        check("post_init_dml", int'(dml_out), 112);
        upd(3, 2);

        // reset asserted during UPD_S aborts the update
        req = 1'b1; req_ch = 2'd1; req_fi = 3'd6;
        tick();
        req = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_ch", int'(done_ch), 0);
        check("mid_rst_dms", int'(dms_out), 0);
        check("mid_rst_dml", int'(dml_out), 0);
        check("mid_rst_drop", int'(drop_cnt), 0);
        tick();
        reset = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) ndone++;
        end
        check("mid_rst_no_done", ndone, 0);
        clear_model();
        upd(1, 7);
        upd(1, 3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
